full_pipeline_sdiv_32s_32s_32_seq: RTL

FULL_PIPELINE_SDIV_32S_32S_32_SEQ -- requirements
Module: full_pipeline_sdiv_32s_32s_32_seq

---
 rtl/full_pipeline_sdiv_32s_32s_32_seq.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/full_pipeline_sdiv_32s_32s_32_seq.sv
// ---------------------------------------------------------------------------
// full_pipeline_sdiv_32s_32s_32_seq
//
// Sequential signed divider (truncating). One restoring radix-2 step is
// performed per enabled clock on unsigned magnitudes, followed by a single
// sign-fixup cycle. Latency is din0_WIDTH+1 enabled cycles from the accepting
// edge. A new start is accepted in the cycle done is high.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   ce           clock enable; low freezes all state and outputs
//   start        request; operands sampled when accepted in IDLE
//   din0         signed dividend
//   din1         signed divisor
//   busy         high while an operation is in flight
//   done         one-enabled-cycle pulse; quot/rem/div_by_zero valid
//   quot         signed quotient, held until next done
//   rem          signed remainder (sign of dividend), held until next done
//   div_by_zero  set with done when the divisor was 0
// ---------------------------------------------------------------------------
module full_pipeline_sdiv_32s_32s_32_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] quot,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  localparam int W     = din0_WIDTH;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Two's-complement negation; the most negative value maps onto itself,
  // which is exactly the wrap behaviour wanted for -2^(W-1) / -1.
  function automatic logic [W-1:0] negate(input logic [W-1:0] x);
    return (~x) + {{(W-1){1'b0}}, 1'b1};
  endfunction

  // Magnitude as a W-bit unsigned value; -2^(W-1) becomes 2^(W-1).
  function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x);
    return x[W-1] ? negate(x) : x;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [W-1:0]      quot_q, quot_d;
  logic [W-1:0]      rem_q, rem_d;
  logic              dbz_out_q, dbz_out_d;

  // Dividend shifts out of the top of dq while quotient bits shift in below.
  logic [W-1:0]      dq_q, dq_d;
  logic [W-1:0]      pr_q, pr_d;
  logic [W-1:0]      dvs_q, dvs_d;
  logic              neg0_q, neg0_d;
  logic              neg1_q, neg1_d;
  logic              dbz_q, dbz_d;

  logic [W:0]        partial;
  logic [W:0]        trial;
  logic              qbit;

  // Trial subtract needs one guard bit: partial < 2*divisor always holds,
  // so trial[W] is a clean borrow flag.
  always_comb begin
    partial = {pr_q, dq_q[W-1]};
    trial   = partial - {1'b0, dvs_q};
    qbit    = ~trial[W];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = done_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dbz_out_d = dbz_out_q;
    dq_d      = dq_q;
    pr_d      = pr_q;
    dvs_d     = dvs_q;
    neg0_d    = neg0_q;
    neg1_d    = neg1_q;
    dbz_d     = dbz_q;

    if (ce) begin
      done_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            dq_d    = magnitude(din0);
            dvs_d   = magnitude(din1);
            pr_d    = '0;
            neg0_d  = din0[W-1];
            neg1_d  = din1[W-1];
            dbz_d   = (din1 == '0);
            cnt_d   = '0;
            state_d = CALC;
          end
        end
        CALC: begin
          pr_d  = qbit ? trial[W-1:0] : partial[W-1:0];
          dq_d  = {dq_q[W-2:0], qbit};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_d = FIX;
          end
        end
        FIX: begin
          // A zero divisor yields an all-ones magnitude quotient; force it
          // to all ones regardless of sign. The remainder then equals the
          // dividend naturally.
          if (dbz_q) begin
            quot_d = '1;
          end else begin
            quot_d = (neg0_q ^ neg1_q) ? negate(dq_q) : dq_q;
          end
          rem_d     = neg0_q ? negate(pr_q) : pr_q;
          dbz_out_d = dbz_q;
          done_d    = 1'b1;
          state_d   = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      dbz_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      dbz_out_q <= dbz_out_d;
    end
  end

  // Working datapath registers are always reloaded on accept, so they
  // need no reset.
  always_ff @(posedge clk) begin
    dq_q   <= dq_d;
    pr_q   <= pr_d;
    dvs_q  <= dvs_d;
    neg0_q <= neg0_d;
    neg1_q <= neg1_d;
    dbz_q  <= dbz_d;
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_out_q;

endmodule
